// File: rtl/invader_bomb.sv
// invader_bomb: invader bomb slots -- periodic spawn, per-frame fall, player hit and bottom-edge retire.
// Optional macro INVADER_BOMB_LFSR_EN: an 8-bit LFSR jitters the spawn period.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   frame             : one-cycle pulse at start of blanking; all motion happens here
//   done              : game over; clears every bomb and the frame counter, blocks spawns
//   shooter_valid/x/y : firing invader present, its left x and bottom y
//   player_x          : left x of the player sprite
//   bomb_active       : per-slot active flag
//   bomb_x, bomb_y    : per-slot left x / top y, slot i at bits [10i+9:10i]
//   player_hit        : one-cycle pulse on the cycle after a frame where any bomb hit
module invader_bomb #(
    parameter int NUM_BOMBS           = 3,
    parameter int BOMB_STEP           = 2,
    parameter int SPAWN_PERIOD        = 48,
    parameter int SCREEN_HEIGHT       = 480,
    parameter int PLAYER_START_Y      = 440,
    parameter int SPRITE_WIDTH_SCALED = 32,
    parameter int PROJ_WIDTH_SCALED   = 4,
    parameter int PROJ_HEIGHT_SCALED  = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame,
    input  logic                      done,
    input  logic                      shooter_valid,
    input  logic [9:0]                shooter_x,
    input  logic [9:0]                shooter_y,
    input  logic [9:0]                player_x,
    output logic [NUM_BOMBS-1:0]      bomb_active,
    output logic [10*NUM_BOMBS-1:0]   bomb_x,
    output logic [10*NUM_BOMBS-1:0]   bomb_y,
    output logic                      player_hit
);

    localparam logic [10:0] STEP11  = 11'(BOMB_STEP);
    localparam logic [10:0] SCR_H   = 11'(SCREEN_HEIGHT);
    localparam logic [10:0] PLY_Y   = 11'(PLAYER_START_Y);
    localparam logic [10:0] SPR_W   = 11'(SPRITE_WIDTH_SCALED);
    localparam logic [10:0] PRJ_W   = 11'(PROJ_WIDTH_SCALED);
    localparam logic [10:0] PRJ_H   = 11'(PROJ_HEIGHT_SCALED);
    localparam logic [9:0]  X_OFF   = 10'(SPRITE_WIDTH_SCALED/2 - PROJ_WIDTH_SCALED/2);
    localparam logic [7:0]  PERIOD  = 8'(SPAWN_PERIOD);

    logic [NUM_BOMBS-1:0] active_q, active_d;
    logic [9:0]           x_q [NUM_BOMBS];
    logic [9:0]           x_d [NUM_BOMBS];
    logic [9:0]           y_q [NUM_BOMBS];
    logic [9:0]           y_d [NUM_BOMBS];
    logic                 hit_q, hit_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [7:0]           wrap_val;
    logic                 attempt;
    logic                 any_hit;
    logic                 spawned;
    logic                 slot_hit;
    logic [10:0]          y_next;

`ifdef INVADER_BOMB_LFSR_EN
    localparam logic [7:0] HALF = 8'(SPAWN_PERIOD/2);
    logic [7:0] lfsr_q, lfsr_d;
    logic [7:0] period_q, period_d;
    logic       lfsr_fb;

    assign wrap_val = period_q;
    // Taps 8,6,5,4 -> bits 7,5,4,3
    assign lfsr_fb  = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

    always_comb begin
        lfsr_d   = lfsr_q;
        period_d = period_q;
        if (!done && frame) begin
            lfsr_d = {lfsr_q[6:0], lfsr_fb};
            // New period is drawn each time the counter wraps
            if (attempt) begin
                period_d = HALF + {3'b000, lfsr_q[4:0]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q   <= 8'h5A;
            period_q <= HALF + 8'h1A;
        end else begin
            lfsr_q   <= lfsr_d;
            period_q <= period_d;
        end
    end
`else
    assign wrap_val = PERIOD;
`endif

    assign attempt = (cnt_q == wrap_val - 8'd1);

    always_comb begin
        active_d = active_q;
        x_d      = x_q;
        y_d      = y_q;
        cnt_d    = cnt_q;
        hit_d    = 1'b0;
        any_hit  = 1'b0;
        spawned  = 1'b0;
        slot_hit = 1'b0;
        y_next   = '0;
        if (done) begin
            active_d = '0;
            cnt_d    = '0;
        end else if (frame) begin
            cnt_d = attempt ? 8'd0 : cnt_q + 8'd1;
            for (int i = 0; i < NUM_BOMBS; i++) begin
                if (active_q[i]) begin
                    slot_hit = ({1'b0, y_q[i]} + PRJ_H > PLY_Y) &&
                               ({1'b0, x_q[i]} < {1'b0, player_x} + SPR_W) &&
                               ({1'b0, x_q[i]} + PRJ_W > {1'b0, player_x});
                    y_next   = {1'b0, y_q[i]} + STEP11;
                    if (slot_hit) begin
                        active_d[i] = 1'b0;
                        any_hit     = 1'b1;
                    end else if (y_next + PRJ_H >= SCR_H) begin
                        active_d[i] = 1'b0;
                    end else begin
                        y_d[i] = y_next[9:0];
                    end
                end
            end
            // Free slots are judged before this frame's retirements, so a slot
            // retiring now is reused no earlier than the next attempt.
            if (attempt && shooter_valid) begin
                for (int i = 0; i < NUM_BOMBS; i++) begin
                    if (!spawned && !active_q[i]) begin
                        spawned     = 1'b1;
                        active_d[i] = 1'b1;
                        x_d[i]      = shooter_x + X_OFF;
                        y_d[i]      = shooter_y;
                    end
                end
            end
            hit_d = any_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= '0;
            hit_q    <= 1'b0;
            cnt_q    <= '0;
            for (int i = 0; i < NUM_BOMBS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            active_q <= active_d;
            hit_q    <= hit_d;
            cnt_q    <= cnt_d;
            for (int i = 0; i < NUM_BOMBS; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
            end
        end
    end

    assign bomb_active = active_q;
    assign player_hit  = hit_q;

    for (genvar g = 0; g < NUM_BOMBS; g++) begin : g_pack
        assign bomb_x[10*g +: 10] = x_q[g];
        assign bomb_y[10*g +: 10] = y_q[g];
    end

endmodule
